sb_stream_gen: RTL and testbench
================================

SB_STREAM_GEN -- requirements
Module: sb_stream_gen

Interface
REQ-001 Parameter: DW, 256, stream data width in bits; SHALL be at least 128.
REQ-002 Parameter: ADD, 42, 64-bit increment the downstream stage applies; used by the response checker.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, level; sampled in IDLE or DONE.
- count, input, 32, number of payload packets; latched on start.
- dest_cfg, input, 32, destination; latched on start.
- tx_data, output, DW, TX payload.
- tx_dest, output, 32, TX destination.
- tx_last, output, 1, TX end-of-packet.
- tx_valid, output, 1, TX valid.
- tx_ready, input, 1, TX ready.
- rx_data, input, DW, response payload.
- rx_dest, input, 32, response destination; ignored.
- rx_last, input, 1, response end-of-packet; ignored.
- rx_valid, input, 1, response valid.
- rx_ready, output, 1, response ready.
- busy, output, 1, high in SEND, TERM and WAIT.
- done, output, 1, high in DONE.
- rx_count, output, 32, responses accepted in the current run.
- err_count, output, 32, response mismatches in the current run.

Function
REQ-004 The FSM SHALL have five states: IDLE, SEND, TERM, WAIT, DONE.
REQ-005 From IDLE or DONE, start=1 SHALL do all of the following on that edge:
- latch count to N and dest_cfg to D;
- clear seq, rx_count and err_count;
- enter SEND if N>0, else enter TERM.
REQ-006 Packets are single-beat; tx_last SHALL be 1 whenever tx_valid=1.
REQ-007 In SEND, tx_valid=1, tx_data={(DW-64) zeros, seq} and tx_dest=D.
REQ-008 A TX beat transfers on a rising edge with tx_valid=1 and tx_ready=1.
REQ-009 In SEND, a transfer SHALL increment seq; the transfer of seq=N-1 SHALL move the FSM to TERM.
REQ-010 In TERM, tx_valid=1 and tx_data is all ones (terminator); its transfer SHALL move the FSM to WAIT.
REQ-011 While tx_valid=1 and tx_ready=0, tx_data, tx_dest and tx_last SHALL hold stable; tx_valid SHALL NOT drop before the transfer.
REQ-012 tx_valid SHALL be 0 in IDLE, WAIT and DONE.
REQ-013 rx_ready SHALL be 1 in SEND, TERM and WAIT, and 0 otherwise.
REQ-014 A response is accepted when rx_valid=1 and rx_ready=1. The accepted beat with index k=rx_count is checked against its expected value:
- k<N: {(DW-64) zeros, (k+ADD) mod 2^64};
- k=N: {(DW-64) ones, (2^64-1+ADD) mod 2^64}, i.e. 41 when ADD=42.
REQ-015 Each mismatch SHALL increment err_count, saturating at 2^32-1.
REQ-016 Each accepted response SHALL increment rx_count.
REQ-017 Acceptance of response k=N SHALL move the FSM to DONE on the same edge; further responses cannot be accepted because rx_ready=0 in DONE.
REQ-018 A TX transfer and an RX acceptance in the same cycle SHALL both take effect.
REQ-019 A response may be accepted before its own request finishes transferring; checking SHALL depend only on k.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 Latency:
- tx_valid rises on the cycle after the start edge;
- back-to-back TX transfers SHALL be sustained at one per cycle when tx_ready=1.

Reset
REQ-022 Assertion of rst SHALL immediately, without waiting for a clock edge, force:
- FSM to IDLE;
- tx_valid, rx_ready, busy, done to 0;
- tx_data, tx_dest, tx_last to 0;
- seq, rx_count, err_count, N and D to 0.
REQ-023 Reset asserted mid-run SHALL abort the run. Nothing is retained, and no TX beat SHALL be presented until a new start.
REQ-024 Release of rst SHALL be synchronous to clk in the enclosing design; the block SHALL leave IDLE only on a start sampled after release.

Verification
REQ-025 Base run: count=3, dest_cfg=5, tx_ready=1, loopback adds 42 with 1-cycle delay.
- TX: 0,1,2 then all-ones, each with tx_dest=5.
- RX: 42,43,44, then {ones,41}.
- End: done=1, rx_count=4, err_count=0.
REQ-026 count=0: the first TX beat is the terminator; DONE after one response; rx_count=1.
REQ-027 Backpressure: tx_ready toggling 1,0,0,1 across beats; tx_data is stable across every stall and no beat is dropped or duplicated.
REQ-028 Corrupted responses: loopback returns 45 for k=1 and {zeros,41} for k=N (count=3); err_count=2 and done=1.
REQ-029 Reset abort: rst asserted mid-SEND after 2 of count=8 transfers.
- tx_valid=0 with no clock edge needed.
- A new start with count=1 yields TX 0, then all-ones.
REQ-030 start held high during SEND has no effect; start asserted in DONE begins a fresh run with counters cleared.

Source files
------------

// File: rtl/sb_stream_gen.sv
// Stream generator: sends N counting packets plus an all-ones terminator, then checks the
// looped-back responses against the expected increment and counts mismatches.
module sb_stream_gen #(
    parameter int unsigned DW  = 256,
    parameter logic [63:0] ADD = 64'd42
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   count,
    input  logic [31:0]   dest_cfg,
    output logic [DW-1:0] tx_data,
    output logic [31:0]   tx_dest,
    output logic          tx_last,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic [31:0]   rx_dest,
    input  logic          rx_last,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          busy,
    output logic          done,
    output logic [31:0]   rx_count,
    output logic [31:0]   err_count
);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StTerm,
        StWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] n_q, n_d;
    logic [31:0] d_q, d_d;
    logic [31:0] rx_count_q, rx_count_d;
    logic [31:0] err_count_q, err_count_d;

    logic          tx_fire;
    logic          rx_fire;
    logic          rx_is_term;
    logic [DW-1:0] rx_exp;

    // Response sideband carries no information the checker needs.
    logic unused_rx;
    assign unused_rx = ^{rx_dest, rx_last};

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_dest  = '0;
        tx_last  = 1'b0;
        rx_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            StSend: begin
                tx_valid = 1'b1;
                tx_data  = {{(DW-32){1'b0}}, seq_q};
                tx_dest  = d_q;
                tx_last  = 1'b1;
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            StTerm: begin
                tx_valid = 1'b1;
                tx_data  = '1;
                tx_dest  = d_q;
                tx_last  = 1'b1;
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            StWait: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;
    assign tx_fire   = tx_valid & tx_ready;
    assign rx_fire   = rx_valid & rx_ready;

    // Expected response depends only on its index, not on what has been sent so far.
    assign rx_is_term = (rx_count_q == n_q);
    always_comb begin
        if (rx_is_term) begin
            rx_exp = {{(DW-64){1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF + ADD};
        end else begin
            rx_exp = {{(DW-64){1'b0}}, {32'd0, rx_count_q} + ADD};
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        n_d         = n_q;
        d_d         = d_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    n_d         = count;
                    d_d         = dest_cfg;
                    seq_d       = '0;
                    rx_count_d  = '0;
                    err_count_d = '0;
                    state_d     = (count != 32'd0) ? StSend : StTerm;
                end
            end
            StSend: begin
                if (tx_fire) begin
                    seq_d = seq_q + 32'd1;
                    if (seq_q == n_q - 32'd1) begin
                        state_d = StTerm;
                    end
                end
            end
            StTerm: begin
                if (tx_fire) begin
                    state_d = StWait;
                end
            end
            StWait: ;
            default: state_d = StIdle;
        endcase

        // rx_ready is only high in active states, so this never overlaps a start.
        if (rx_fire) begin
            rx_count_d = rx_count_q + 32'd1;
            if ((rx_data != rx_exp) && (err_count_q != 32'hFFFF_FFFF)) begin
                err_count_d = err_count_q + 32'd1;
            end
            if (rx_is_term) begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            seq_q       <= '0;
            n_q         <= '0;
            d_q         <= '0;
            rx_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            n_q         <= n_d;
            d_q         <= d_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_sb_stream_gen.sv
// Directed bench for sb_stream_gen: table of full runs through a +ADD loopback model, plus
// hand-written sequences for reset abort, start held while busy and restart from done.
module tb_sb_stream_gen;

    localparam int unsigned DW  = 256;
    localparam logic [63:0] ADD = 64'd42;

    logic          clk;
    logic          rst;
    logic          start;
    logic [31:0]   count;
    logic [31:0]   dest_cfg;
    logic [DW-1:0] tx_data;
    logic [31:0]   tx_dest;
    logic          tx_last;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic [31:0]   rx_dest;
    logic          rx_last;
    logic          rx_valid;
    logic          rx_ready;
    logic          busy;
    logic          done;
    logic [31:0]   rx_count;
    logic [31:0]   err_count;

    sb_stream_gen #(.DW(DW), .ADD(ADD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .dest_cfg  (dest_cfg),
        .tx_data   (tx_data),
        .tx_dest   (tx_dest),
        .tx_last   (tx_last),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_dest   (rx_dest),
        .rx_last   (rx_last),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .done      (done),
        .rx_count  (rx_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] dest;
        int unsigned ready_mode;
        bit          corrupt;
        logic [31:0] exp_rx;
        logic [31:0] exp_err;
    } vec_t;

    vec_t vecs [4];

    int unsigned   n_checks;
    int unsigned   n_fail;
    logic [DW-1:0] rsp_q [$];
    logic [DW-1:0] tx_log [$];
    int unsigned   cyc;
    int unsigned   ready_mode;
    bit            corrupt_mode;
    int unsigned   tx_k;
    logic [31:0]   cur_n;
    logic [31:0]   cur_dest;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    bit            pat [4];
    logic [DW-1:0] ones;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, update the loopback after the rising edge.
    task automatic tick();
        bit            txf;
        bit            rxf;
        logic [DW-1:0] td;
        logic [DW-1:0] rsp;
        @(negedge clk);
        if (prev_stall) begin
            check("stall_valid", tx_valid, 1);
            check("stall_data", tx_data, prev_data);
        end
        txf = tx_valid && tx_ready;
        rxf = rx_valid && rx_ready;
        td  = tx_data;
        if (txf) begin
            check("tx_dest", tx_dest, cur_dest);
            check("tx_last", tx_last, 1);
            tx_log.push_back(td);
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = td;
        @(posedge clk);
        #1;
        if (rxf) void'(rsp_q.pop_front());
        if (txf) begin
            rsp = {td[DW-1:64], td[63:0] + ADD};
            if (corrupt_mode && tx_k == 1) rsp[63:0] = 64'd45;
            if (corrupt_mode && tx_k == cur_n) rsp = {{(DW-64){1'b0}}, 64'd41};
            rsp_q.push_back(rsp);
            tx_k++;
        end
        rx_valid = (rsp_q.size() > 0);
        rx_last  = rx_valid;
        rx_data  = rx_valid ? rsp_q[0] : '0;
        cyc++;
        tx_ready = (ready_mode == 1) ? pat[cyc % 4] : 1'b1;
    endtask

    task automatic setup_run(input logic [31:0] n, input logic [31:0] dest, input int unsigned mode,
                             input bit corrupt);
        cur_n        = n;
        cur_dest     = dest;
        tx_k         = 0;
        tx_log.delete();
        ready_mode   = mode;
        corrupt_mode = corrupt;
        count        = n;
        dest_cfg     = dest;
    endtask

    task automatic start_run(input logic [31:0] n, input logic [31:0] dest,
                             input int unsigned mode, input bit corrupt);
        setup_run(n, dest, mode, corrupt);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_tx_valid", tx_valid, 1);
        check("start_busy", busy, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            tick();
        end
        check("run_done", done, 1);
    endtask

    task automatic check_run(input logic [31:0] n, input logic [31:0] exp_rx,
                             input logic [31:0] exp_err);
        logic [DW-1:0] exp;
        check("tx_beats", tx_log.size(), n + 1);
        for (int i = 0; i < tx_log.size() && i <= int'(n); i++) begin
            exp = (i == int'(n)) ? ones : DW'(i);
            check("tx_beat_data", tx_log[i], exp);
        end
        check("rx_count", rx_count, exp_rx);
        check("err_count", err_count, exp_err);
        check("end_busy", busy, 0);
        check("end_tx_valid", tx_valid, 0);
        check("end_rx_ready", rx_ready, 0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        ready_mode = 0;
        prev_stall = 1'b0;
        ones       = '1;
        pat        = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst        = 1'b0;
        start      = 1'b0;
        count      = '0;
        dest_cfg   = '0;
        tx_ready   = 1'b1;
        rx_data    = '0;
        rx_dest    = '0;
        rx_last    = 1'b0;
        rx_valid   = 1'b0;

        vecs[0] = '{cnt: 3, dest: 5, ready_mode: 0, corrupt: 0, exp_rx: 4, exp_err: 0};
        vecs[1] = '{cnt: 0, dest: 9, ready_mode: 0, corrupt: 0, exp_rx: 1, exp_err: 0};
        vecs[2] = '{cnt: 5, dest: 7, ready_mode: 1, corrupt: 0, exp_rx: 6, exp_err: 0};
        vecs[3] = '{cnt: 3, dest: 5, ready_mode: 0, corrupt: 1, exp_rx: 4, exp_err: 2};

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_err_count", err_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("idle_tx_valid", tx_valid, 0);

        for (int v = 0; v < 4; v++) begin
            start_run(vecs[v].cnt, vecs[v].dest, vecs[v].ready_mode, vecs[v].corrupt);
            wait_done();
            check_run(vecs[v].cnt, vecs[v].exp_rx, vecs[v].exp_err);
            ready_mode = 0;
            tx_ready   = 1'b1;
            tick();
        end

        // Restart from DONE clears the counters left over from the corrupted run.
        start_run(2, 11, 0, 0);
        check("restart_err_clr", err_count, 0);
        check("restart_done_clr", done, 0);
        wait_done();
        check_run(2, 3, 0);

        // start held high through SEND with a different count must be ignored.
        setup_run(3, 4, 0, 0);
        start = 1'b1;
        tick();
        count = 32'd9;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b0;
        check("held_start_busy", busy, 1);
        wait_done();
        check_run(3, 4, 0);

        // Reset abort after two of eight transfers.
        start_run(8, 3, 0, 0);
        for (int i = 0; i < 20 && tx_log.size() < 2; i++) tick();
        check("abort_progress", tx_log.size(), 2);
        #2 rst = 1'b1;
        #1;
        check("abort_tx_valid", tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rx_count", rx_count, 0);
        check("abort_tx_data", tx_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_q.delete();
        rx_valid   = 1'b0;
        rx_last    = 1'b0;
        rx_data    = '0;
        prev_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_abort_idle", tx_valid, 0);
        end
        start_run(1, 6, 0, 0);
        wait_done();
        check_run(1, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
